// File: rtl/stencil_mem_pkg.sv
// Shared types and helpers for the stencil memory responder.
package stencil_mem_pkg;

  typedef enum logic {IDLE, RUN} eng_state_t;

  localparam int          WORD_BYTES = 4;
  localparam logic [31:0] POISON     = 32'hDEAD_BEEF;

  // Unwrapped word offset from the window base; callers truncate to the RAM index width.
  function automatic logic [31:0] word_offset(input logic [31:0] addr, input logic [31:0] base);
    return (addr - base) >> 2;
  endfunction

endpackage

// File: rtl/stencil_mem_skid.sv
// Two-entry valid/ready buffer with registered outputs; in_ready depends only on occupancy.
module stencil_mem_skid #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic [1:0]       count;
  logic [WIDTH-1:0] spare;
  logic             push, pop;

  assign in_ready  = (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count    <= 2'd0;
      out_data <= '0;
      spare    <= '0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          if (count == 2'd0) out_data <= in_data;
          else               spare    <= in_data;
          count <= count + 2'd1;
        end
        2'b01: begin
          if (count == 2'd2) out_data <= spare;
          count <= count - 2'd1;
        end
        // Push only happens below two entries and pop needs one, so count is 1 here.
        2'b11: out_data <= in_data;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/stencil_mem_responder.sv
// Burst read/write responder over a dual-port word RAM.
// Define STENCIL_MEM_RANGE_CHECK_EN to add the sticky ERR output and out-of-window poisoning.
module stencil_mem_responder
  import stencil_mem_pkg::*;
#(
  parameter int          DEPTH     = 4096,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] READ_ADDR,
  input  logic [15:0] READ_COUNT,
  input  logic        READ_REQ,
  output logic        READ_BUSY,
  output logic [31:0] READ_DATA,
  output logic        READ_VALID,
  input  logic        READ_READY,
  input  logic [31:0] WRITE_ADDR,
  input  logic [15:0] WRITE_COUNT,
  input  logic        WRITE_REQ,
  output logic        WRITE_BUSY,
  input  logic [31:0] WRITE_DATA,
  input  logic        WRITE_VALID,
  output logic        WRITE_READY
`ifdef STENCIL_MEM_RANGE_CHECK_EN
  ,
  output logic        ERR
`endif
);

  localparam int IDX_W = $clog2(DEPTH);

  logic [31:0] mem [DEPTH];

  // ---------------- read engine ----------------
  eng_state_t       rd_state, rd_state_nx;
  logic [31:0]      rd_addr;
  logic [15:0]      rd_issue_left, rd_beat_left;
  logic             rd_accept, rd_issue, rd_pop, rd_slot;
  logic [IDX_W-1:0] rd_idx;
  logic [31:0]      rd_word;

  assign rd_accept = READ_REQ && (rd_state == IDLE);
  assign rd_issue  = (rd_state == RUN) && (rd_issue_left != 16'd0) && rd_slot;
  assign rd_pop    = READ_VALID && READ_READY;
  assign rd_idx    = IDX_W'(word_offset(rd_addr, BASE_ADDR));
  assign READ_BUSY = (rd_state == RUN);

  always_comb begin
    rd_state_nx = rd_state;
    unique case (rd_state)
      IDLE: if (READ_REQ && READ_COUNT != 16'd0) rd_state_nx = RUN;
      RUN:  if (rd_pop && rd_beat_left == 16'd1) rd_state_nx = IDLE;
    endcase
  end

  // Issue and handshake counts are tracked separately so the skid can hold read-ahead beats.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rd_state      <= IDLE;
      rd_addr       <= '0;
      rd_issue_left <= '0;
      rd_beat_left  <= '0;
    end else begin
      rd_state <= rd_state_nx;
      if (rd_accept) begin
        rd_addr       <= READ_ADDR;
        rd_issue_left <= READ_COUNT;
        rd_beat_left  <= READ_COUNT;
      end else begin
        if (rd_issue) begin
          rd_addr       <= rd_addr + 32'(WORD_BYTES);
          rd_issue_left <= rd_issue_left - 16'd1;
        end
        if (rd_pop) rd_beat_left <= rd_beat_left - 16'd1;
      end
    end
  end

  // The skid's head register doubles as the RAM read register: one cycle of read latency.
  stencil_mem_skid #(.WIDTH(32)) u_skid (
    .clk       (CLK),
    .rst       (RST),
    .in_valid  (rd_issue),
    .in_ready  (rd_slot),
    .in_data   (rd_word),
    .out_valid (READ_VALID),
    .out_ready (READ_READY),
    .out_data  (READ_DATA)
  );

  // ---------------- write engine ----------------
  eng_state_t       wr_state, wr_state_nx;
  logic [31:0]      wr_addr;
  logic [15:0]      wr_left;
  logic             wr_accept, wr_fire, wr_en;
  logic [IDX_W-1:0] wr_idx;

  assign wr_accept   = WRITE_REQ && (wr_state == IDLE);
  assign wr_fire     = WRITE_VALID && WRITE_READY;
  assign wr_idx      = IDX_W'(word_offset(wr_addr, BASE_ADDR));
  assign WRITE_BUSY  = (wr_state == RUN);
  assign WRITE_READY = (wr_state == RUN);

  always_comb begin
    wr_state_nx = wr_state;
    unique case (wr_state)
      IDLE: if (WRITE_REQ && WRITE_COUNT != 16'd0) wr_state_nx = RUN;
      RUN:  if (wr_fire && wr_left == 16'd1) wr_state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_state <= IDLE;
      wr_addr  <= '0;
      wr_left  <= '0;
    end else begin
      wr_state <= wr_state_nx;
      if (wr_accept) begin
        wr_addr <= WRITE_ADDR;
        wr_left <= WRITE_COUNT;
      end else if (wr_fire) begin
        wr_addr <= wr_addr + 32'(WORD_BYTES);
        wr_left <= wr_left - 16'd1;
      end
    end
  end

  // ---------------- range check / RAM ----------------
`ifdef STENCIL_MEM_RANGE_CHECK_EN
  localparam logic [31:0] SPAN = 32'(DEPTH * WORD_BYTES);

  logic rd_in_range, wr_in_range;

  assign rd_in_range = (rd_addr - BASE_ADDR) < SPAN;
  assign wr_in_range = (wr_addr - BASE_ADDR) < SPAN;
  assign rd_word     = rd_in_range ? mem[rd_idx] : POISON;
  assign wr_en       = wr_fire && wr_in_range;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) ERR <= 1'b0;
    else if ((rd_issue && !rd_in_range) || (wr_fire && !wr_in_range)) ERR <= 1'b1;
  end
`else
  assign rd_word = mem[rd_idx];
  assign wr_en   = wr_fire;
`endif

  // Read samples the array before this edge's write lands, giving read-first collisions.
  always_ff @(posedge CLK) begin
    if (wr_en) mem[wr_idx] <= WRITE_DATA;
  end

endmodule

// File: tb/tb_stencil_mem_responder.sv
// Scoreboard bench for stencil_mem_responder (DEPTH=16, non-zero base).
module tb_stencil_mem_responder;

  localparam int          DEP  = 16;
  localparam logic [31:0] BASE = 32'h1000_0000;

  logic        CLK, RST;
  logic [31:0] READ_ADDR, READ_DATA, WRITE_ADDR, WRITE_DATA;
  logic [15:0] READ_COUNT, WRITE_COUNT;
  logic        READ_REQ, READ_BUSY, READ_VALID, READ_READY;
  logic        WRITE_REQ, WRITE_BUSY, WRITE_VALID, WRITE_READY;
`ifdef STENCIL_MEM_RANGE_CHECK_EN
  logic        ERR;
`endif

  stencil_mem_responder #(.DEPTH(DEP), .BASE_ADDR(BASE)) dut (
    .CLK(CLK), .RST(RST),
    .READ_ADDR(READ_ADDR), .READ_COUNT(READ_COUNT), .READ_REQ(READ_REQ),
    .READ_BUSY(READ_BUSY), .READ_DATA(READ_DATA), .READ_VALID(READ_VALID),
    .READ_READY(READ_READY),
    .WRITE_ADDR(WRITE_ADDR), .WRITE_COUNT(WRITE_COUNT), .WRITE_REQ(WRITE_REQ),
    .WRITE_BUSY(WRITE_BUSY), .WRITE_DATA(WRITE_DATA), .WRITE_VALID(WRITE_VALID),
    .WRITE_READY(WRITE_READY)
`ifdef STENCIL_MEM_RANGE_CHECK_EN
    , .ERR(ERR)
`endif
  );

  always #5 CLK = ~CLK;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mdl_mem [DEP];
  logic        prev_stall = 1'b0;
  logic [31:0] prev_data  = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mdl_read(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
`ifdef STENCIL_MEM_RANGE_CHECK_EN
    if (off >= 32'(4 * DEP)) return 32'hDEAD_BEEF;
`endif
    return mdl_mem[int'((off >> 2) % 32'(DEP))];
  endfunction

  task automatic mdl_write(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] off;
    off = a - BASE;
`ifdef STENCIL_MEM_RANGE_CHECK_EN
    if (off >= 32'(4 * DEP)) return;
`endif
    mdl_mem[int'((off >> 2) % 32'(DEP))] = d;
  endtask

  // Read-side monitor: pops the scoreboard on every handshake and checks stall stability.
  always @(negedge CLK) begin
    if (RST) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("rd_hold_valid", 32'(READ_VALID), 32'd1);
        chk("rd_hold_data", READ_DATA, prev_data);
      end
      if (READ_VALID && READ_READY) begin
        if (exp_q.size() == 0) chk("rd_extra_beat", 32'(exp_q.size()), 32'd1);
        else                   chk("rd_data", READ_DATA, exp_q.pop_front());
      end
      prev_stall = READ_VALID && !READ_READY;
      prev_data  = READ_DATA;
    end
  end

  // Starts in the cycle the request is driven (cycle 0); returns at the negedge of the cycle BUSY is low.
  task automatic wr_burst(input logic [31:0] addr, input int cnt, input logic [31:0] seed,
                          output int first_r, output int fall, output int n);
    WRITE_ADDR = addr; WRITE_COUNT = 16'(cnt); WRITE_REQ = 1'b1;
    WRITE_VALID = 1'b1; WRITE_DATA = seed;
    n = 0; first_r = -1; fall = -1;
    @(posedge CLK); #1 WRITE_REQ = 1'b0;
    for (int cyc = 1; cyc < 200; cyc++) begin
      WRITE_DATA = seed + 32'(n);
      @(negedge CLK);
      if (!WRITE_BUSY) begin fall = cyc; break; end
      if (WRITE_READY) begin
        if (first_r < 0) first_r = cyc;
        mdl_write(addr + 32'(4 * n), WRITE_DATA);
        n++;
      end
      @(posedge CLK); #1;
    end
    WRITE_VALID = 1'b0;
  endtask

  // mode 0: READY always high; mode 1: READY follows 1,0,0,1 by cycle number.
  task automatic rd_burst(input logic [31:0] addr, input int cnt, input int mode,
                          output int first_v, output int fall);
    READ_ADDR = addr; READ_COUNT = 16'(cnt); READ_REQ = 1'b1;
    for (int i = 0; i < cnt; i++) exp_q.push_back(mdl_read(addr + 32'(4 * i)));
    first_v = -1; fall = -1;
    @(posedge CLK); #1 READ_REQ = 1'b0;
    for (int cyc = 1; cyc < 400; cyc++) begin
      READ_READY = (mode == 0) || (cyc % 4 == 0) || (cyc % 4 == 3);
      @(negedge CLK);
      if (READ_VALID && first_v < 0) first_v = cyc;
      if (!READ_BUSY) begin fall = cyc; break; end
      @(posedge CLK); #1;
    end
    chk("rd_leftover", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    int fr, fv, fall, n, beats;
    CLK = 1'b0; RST = 1'b1;
    READ_ADDR = '0; READ_COUNT = '0; READ_REQ = 1'b0; READ_READY = 1'b0;
    WRITE_ADDR = '0; WRITE_COUNT = '0; WRITE_REQ = 1'b0; WRITE_DATA = '0; WRITE_VALID = 1'b0;

    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("rst_rd_busy", 32'(READ_BUSY), 32'd0);
    chk("rst_rd_valid", 32'(READ_VALID), 32'd0);
    chk("rst_rd_data", READ_DATA, 32'd0);
    chk("rst_wr_busy", 32'(WRITE_BUSY), 32'd0);
    chk("rst_wr_ready", 32'(WRITE_READY), 32'd0);
`ifdef STENCIL_MEM_RANGE_CHECK_EN
    chk("rst_err", 32'(ERR), 32'd0);
`endif
    @(posedge CLK); #1 RST = 1'b0;

    // Fill the whole RAM with known data.
    wr_burst(BASE, 16, 32'd100, fr, fall, n);
    chk("fill_fall", 32'(fall), 32'd17);
    chk("fill_beats", 32'(n), 32'd16);

    @(posedge CLK); #1;
    wr_burst(BASE + 32'h10, 4, 32'd1, fr, fall, n);
    chk("wr4_first_ready", 32'(fr), 32'd1);
    chk("wr4_fall", 32'(fall), 32'd5);
    chk("wr4_beats", 32'(n), 32'd4);

    @(posedge CLK); #1;
    rd_burst(BASE + 32'h10, 4, 0, fv, fall);
    chk("rd4_first_valid", 32'(fv), 32'd2);
    chk("rd4_fall", 32'(fall), 32'd6);

    // Re-request in the cycle BUSY falls, with a stalling initiator.
    rd_burst(BASE + 32'h20, 8, 1, fv, fall);
    chk("rd_reissue_first_valid", 32'(fv), 32'd2);

    // Zero-count requests on both channels, each followed immediately by a real one.
    @(posedge CLK); #1;
    rd_burst(BASE, 0, 0, fv, fall);
    chk("rd0_fall", 32'(fall), 32'd1);
    chk("rd0_no_valid", 32'(fv), 32'hFFFF_FFFF);
    rd_burst(BASE + 32'h8, 1, 0, fv, fall);
    chk("rd_after0_first_valid", 32'(fv), 32'd2);
    wr_burst(BASE, 0, 32'd0, fr, fall, n);
    chk("wr0_fall", 32'(fall), 32'd1);
    chk("wr0_beats", 32'(n), 32'd0);
    wr_burst(BASE + 32'h30, 2, 32'd50, fr, fall, n);
    chk("wr_after0_first_ready", 32'(fr), 32'd1);
    chk("wr_after0_fall", 32'(fall), 32'd3);

`ifdef STENCIL_MEM_RANGE_CHECK_EN
    chk("err_clean", 32'(ERR), 32'd0);
`endif

    // Write running off the end of the window at word 14.
    @(posedge CLK); #1;
    wr_burst(BASE + 32'd56, 4, 32'hA, fr, fall, n);
    chk("wrap_wr_fall", 32'(fall), 32'd5);
`ifdef STENCIL_MEM_RANGE_CHECK_EN
    chk("err_set", 32'(ERR), 32'd1);
`endif
    rd_burst(BASE + 32'd56, 4, 0, fv, fall);
    rd_burst(BASE, 2, 0, fv, fall);
    rd_burst(BASE + 32'h30, 2, 1, fv, fall);

    // Reset in the middle of a 10-beat read, after the third beat.
    @(posedge CLK); #1;
    READ_ADDR = BASE; READ_COUNT = 16'd10; READ_REQ = 1'b1; READ_READY = 1'b1;
    for (int i = 0; i < 10; i++) exp_q.push_back(mdl_read(BASE + 32'(4 * i)));
    @(posedge CLK); #1 READ_REQ = 1'b0;
    beats = 0;
    for (int g = 0; g < 50 && beats < 3; g++) begin
      @(negedge CLK);
      if (READ_VALID && READ_READY) beats++;
      @(posedge CLK);
    end
    chk("mid_rst_beats", 32'(beats), 32'd3);
    #2 RST = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(READ_VALID), 32'd0);
    chk("mid_rst_busy", 32'(READ_BUSY), 32'd0);
    chk("mid_rst_data", READ_DATA, 32'd0);
    exp_q.delete();
    @(posedge CLK); #1 RST = 1'b0;
    rd_burst(BASE + 32'h4, 2, 0, fv, fall);
    chk("post_rst_first_valid", 32'(fv), 32'd2);
    chk("post_rst_fall", 32'(fall), 32'd4);

    // Count larger than the RAM.
    @(posedge CLK); #1;
    rd_burst(BASE, 20, 1, fv, fall);
    chk("rd20_first_valid", 32'(fv), 32'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
